// File: rtl/mix_relu.sv
// mix_relu: ReLU activation stage after the mix-layer dot/bias stage.
// Forward pass walks the pre-activation vector one element per cycle, writing
// the activated value and a derivative mask bit. Backward pass gates the
// incoming gradient with the stored mask in a single cycle.
module mix_relu #(
  parameter int unsigned N_LEN   = 16,
  parameter int unsigned HID_DIM = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  output logic                       valid,
  input  logic [HID_DIM*N_LEN-1:0]   d,
  output logic [HID_DIM*N_LEN-1:0]   q,
  output logic [HID_DIM-1:0]         mask,
  input  logic                       run_b,
  input  logic [HID_DIM*N_LEN-1:0]   dy,
  output logic [HID_DIM*N_LEN-1:0]   dx,
  output logic                       valid_b
);

  localparam int unsigned CNT_W = $clog2(HID_DIM + 1);
  localparam int unsigned IDX_W = (HID_DIM > 1) ? $clog2(HID_DIM) : 1;
  localparam int unsigned VEC_W = HID_DIM * N_LEN;

  logic [CNT_W-1:0] cnt;
  logic             done_b;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [N_LEN-1:0] elem;
  logic             elem_pos;
  logic [VEC_W-1:0] dx_gated;

  // Current forward element; index clamped so the select never leaves the vector
  always_comb begin
    in_range = (cnt < CNT_W'(HID_DIM));
    idx      = '0;
    if (in_range) begin
      idx = IDX_W'(cnt);
    end
    elem     = d[idx*N_LEN +: N_LEN];
    elem_pos = ~elem[N_LEN-1] & (|elem);
  end

  // Forward pass: one element per cycle, saturating at HID_DIM, restart on run low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      q    <= '0;
      mask <= '0;
    end else if (run) begin
      if (in_range) begin
        q[idx*N_LEN +: N_LEN] <= elem_pos ? elem : '0;
        mask[idx]             <= elem_pos;
        cnt                   <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Gradient gated by the mask from the last forward pass
  always_comb begin
    dx_gated = '0;
    for (int i = 0; i < int'(HID_DIM); i++) begin
      if (mask[i]) begin
        dx_gated[i*N_LEN +: N_LEN] = dy[i*N_LEN +: N_LEN];
      end
    end
  end

  // Backward pass: single parallel update, stalled while the forward pass runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx     <= '0;
      done_b <= 1'b0;
    end else if (!run_b) begin
      done_b <= 1'b0;
    end else if (!run && !done_b) begin
      dx     <= dx_gated;
      done_b <= 1'b1;
    end
  end

  // Completion flags follow the enables immediately
  always_comb begin
    valid   = run & (cnt == CNT_W'(HID_DIM));
    valid_b = run_b & done_b;
  end

endmodule

// File: tb/tb_mix_relu.sv
// Directed self-checking bench for mix_relu.
module tb_mix_relu;

  localparam int unsigned N = 16;
  localparam int unsigned H = 12;
  localparam int unsigned W = N * H;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         run;
  logic         run_b;
  logic [W-1:0] d;
  logic [W-1:0] dy;
  logic [W-1:0] q;
  logic [W-1:0] dx;
  logic [H-1:0] mask;
  logic         valid;
  logic         valid_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_relu #(.N_LEN(N), .HID_DIM(H)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .valid   (valid),
    .d       (d),
    .q       (q),
    .mask    (mask),
    .run_b   (run_b),
    .dy      (dy),
    .dx      (dx),
    .valid_b (valid_b)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] fill(input logic [N-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(H); i++) r[i*N +: N] = v;
    return r;
  endfunction

  // Expected backward result: dy word where mask bit set, zero elsewhere
  function automatic logic [W-1:0] gate(input logic [H-1:0] m, input logic [N-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(H); i++) if (m[i]) r[i*N +: N] = g;
    return r;
  endfunction

  initial begin
    logic [W-1:0] exp_q;
    logic [W-1:0] old_dx;
    logic [H-1:0] m;

    // Reset with garbage inputs and both enables high
    rst_n = 1'b0;
    run   = 1'b1;
    run_b = 1'b1;
    d     = {6{32'hDEAD_BEEF}};
    dy    = {6{32'h1234_5678}};
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_q", q, '0);
      chk("rst_mask", W'(mask), '0);
      chk("rst_dx", dx, '0);
      chk("rst_valid", W'(valid), '0);
      chk("rst_valid_b", W'(valid_b), '0);
      tick();
    end
    rst_n = 1'b1;
    run   = 1'b0;
    run_b = 1'b0;
    tick();

    // Forward pass: +1.0, -1.0, 0, +0.5 repeating
    for (int i = 0; i < int'(H); i++) begin
      case (i % 4)
        0:       d[i*N +: N] = 16'h0100;
        1:       d[i*N +: N] = 16'hFF00;
        2:       d[i*N +: N] = 16'h0000;
        default: d[i*N +: N] = 16'h0080;
      endcase
    end
    run = 1'b1;
    #1;
    chk("fwd_valid_pre", W'(valid), '0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("fwd_valid", W'(valid), W'(k >= 12));
    end
    exp_q = '0;
    for (int i = 0; i < int'(H); i++) begin
      if (i % 4 == 0) exp_q[i*N +: N] = 16'h0100;
      if (i % 4 == 3) exp_q[i*N +: N] = 16'h0080;
    end
    chk("fwd_q", q, exp_q);
    chk("fwd_mask", W'(mask), W'(12'h999));
    run = 1'b0;
    #1;
    chk("fwd_valid_drop", W'(valid), '0);
    tick();

    // Aborted pass of 5 cycles, then a full pass with all 7FFF
    run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_valid", W'(valid), '0);
    end
    run = 1'b0;
    tick();
    d   = fill(16'h7FFF);
    run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 11) chk("full_valid", W'(valid), W'(k == 12));
    end
    chk("full_q", q, fill(16'h7FFF));
    chk("full_mask", W'(mask), W'(12'hFFF));
    run = 1'b0;
    tick();

    // Partial pass of negatives: first 5 elements rewritten, rest keep 7FFF
    d   = fill(16'hFF00);
    run = 1'b1;
    repeat (5) tick();
    run = 1'b0;
    tick();
    exp_q = fill(16'h7FFF);
    for (int i = 0; i < 5; i++) exp_q[i*N +: N] = 16'h0000;
    chk("part_q", q, exp_q);
    chk("part_mask", W'(mask), W'(12'hFE0));

    // Forward pass producing mask A5A, then backward with dy = 0200
    m = 12'hA5A;
    for (int i = 0; i < int'(H); i++) d[i*N +: N] = m[i] ? 16'h0100 : 16'hFF80;
    run = 1'b1;
    repeat (12) tick();
    chk("a5a_valid", W'(valid), W'(1'b1));
    run = 1'b0;
    tick();
    chk("a5a_mask", W'(mask), W'(12'hA5A));
    dy    = fill(16'h0200);
    run_b = 1'b1;
    #1;
    chk("bwd_valid_b_pre", W'(valid_b), '0);
    tick();
    chk("bwd_valid_b", W'(valid_b), W'(1'b1));
    chk("bwd_dx", dx, gate(12'hA5A, 16'h0200));
    tick();
    chk("bwd_valid_b_hold", W'(valid_b), W'(1'b1));
    run_b = 1'b0;
    #1;
    chk("bwd_valid_b_drop", W'(valid_b), '0);
    tick();

    // Simultaneous run and run_b: backward stalls until run drops
    old_dx = gate(12'hA5A, 16'h0200);
    m = 12'h0F0;
    for (int i = 0; i < int'(H); i++) d[i*N +: N] = m[i] ? 16'h0040 : 16'h8000;
    dy    = fill(16'h0300);
    run   = 1'b1;
    run_b = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("sim_valid_b", W'(valid_b), '0);
    end
    chk("sim_valid", W'(valid), W'(1'b1));
    chk("sim_dx_hold", dx, old_dx);
    run = 1'b0;
    #1;
    chk("sim_valid_b_pre", W'(valid_b), '0);
    tick();
    chk("sim_valid_b_go", W'(valid_b), W'(1'b1));
    chk("sim_mask", W'(mask), W'(12'h0F0));
    chk("sim_dx", dx, gate(12'h0F0, 16'h0300));
    run_b = 1'b0;
    tick();

    // Asynchronous reset at cnt = 6, then backward-only pass
    d   = fill(16'h0100);
    run = 1'b1;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q, '0);
    chk("mid_rst_mask", W'(mask), '0);
    chk("mid_rst_dx", dx, '0);
    chk("mid_rst_valid", W'(valid), '0);
    chk("mid_rst_valid_b", W'(valid_b), '0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    dy    = fill(16'h0400);
    run_b = 1'b1;
    tick();
    chk("post_rst_valid_b", W'(valid_b), W'(1'b1));
    chk("post_rst_dx", dx, '0);
    chk("post_rst_q", q, '0);
    run_b = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_relu.md
Name: mix_relu

Overview:
- Activation stage directly downstream of the mix-layer dot/bias stage.
- Forward pass: consumes the HID_DIM-wide pre-activation vector, applies ReLU one element per cycle, and records a derivative mask for training.
- Backward pass: gates the incoming gradient vector with the stored mask, producing the gradient fed back to the dot stage.

Parameters:
- N_LEN, 16, fixed-point word width (`N_LEN from consts_train.vh)
- F_LEN, 8, fractional bits (`F_LEN); 1.0 = 16'h0100
- HID_DIM, 12, vector length (`HID_DIM)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  forward enable; driven by upstream valid and held high until the controller drops it
- valid  output  1  forward result complete
- d  input  HID_DIM*N_LEN  pre-activation vector, element i at [i*N_LEN +: N_LEN]; stable while run is high
- q  output  HID_DIM*N_LEN  activated vector, same packing
- mask  output  HID_DIM  bit i = 1 when d[i] > 0 in the last forward pass
- run_b  input  1  backward enable, level-held like run
- dy  input  HID_DIM*N_LEN  upstream gradient; stable while run_b is high
- dx  output  HID_DIM*N_LEN  masked gradient
- valid_b  output  1  backward result complete

Behaviour:
- Reset (async, rst_n = 0): q, mask, dx, the forward counter cnt, the backward flag done_b, valid and valid_b are all 0, immediately and independent of clk.

Forward pass:
- cnt is a $clog2(HID_DIM+1)-bit counter.
- Each posedge with run = 1 and cnt < HID_DIM:
  - if d[cnt] is negative or zero: q[cnt] <= 0 and mask[cnt] <= 0;
  - otherwise: q[cnt] <= d[cnt] and mask[cnt] <= 1;
  - then cnt <= cnt + 1.
- Only the sign bit and a zero test are used. No arithmetic; there is no width change.
- At cnt == HID_DIM, cnt holds (saturates) and q/mask hold.
- valid = run & (cnt == HID_DIM), combinational. It first rises HID_DIM cycles after the first posedge with run = 1, and stays high while run stays high.
- run = 0: cnt <= 0 on the next posedge, and valid drops immediately. q and mask keep their values so the backward pass can use them.
- run dropped mid-pass: elements already written keep their new values and the remaining elements keep their old values. The next run rewrites all HID_DIM elements from index 0.

Backward pass:
- Each posedge with run_b = 1, run = 0 and done_b = 0: every element i gets dx[i] <= mask[i] ? dy[i] : 0, all in parallel, and done_b <= 1.
- valid_b = run_b & done_b, so it is high exactly 1 cycle after the first enabled posedge.
- run_b = 0: done_b <= 0 on the next posedge; dx holds.

Simultaneous events:
- run and run_b both high: forward has priority. The backward pass stalls with done_b frozen, valid_b stays low and dx is not written. Backward resumes when run drops.
- run_b asserted with no prior forward pass: uses mask = 0, so dx = 0.

Other rules:
- Reset mid-operation: everything clears. mask = 0, so a following backward pass without a new forward pass yields dx = 0.
- No combinational path from d or dy to q or dx. Outputs are registered; only valid and valid_b are combinational.

Test Plan:
- Reset with garbage on d/dy and run = 1 while rst_n = 0 -> q = 0, mask = 12'h000, dx = 0, valid = 0, valid_b = 0 throughout reset.
- d = {+1.0 (16'h0100), -1.0 (16'hFF00), 0, +0.5 (16'h0080), ...} alternating; run high for 14 cycles -> valid first high at posedge 12; q[0] = 16'h0100, q[1] = 0, q[2] = 0, q[3] = 16'h0080; mask bits 0 and 3 set, bits 1 and 2 clear.
- run high 5 cycles then low, d changed to all 16'h7FFF, run reasserted 12 cycles -> valid never asserts in the first window; after the second window q = all 16'h7FFF and mask = 12'hFFF.
- After a forward pass with mask = 12'hA5A, dy = all 16'h0200, run_b high -> valid_b high 1 cycle after run_b; dx[i] = 16'h0200 where the mask bit is 1, else 0.
- run and run_b high together for 14 cycles -> valid_b stays 0 and dx unchanged; run drops -> valid_b asserts 1 cycle later with dx from the new mask.
- rst_n pulsed low at cnt = 6 during a forward pass -> all outputs 0 asynchronously; a subsequent run_b-only pass gives dx = 0.
